reg_file_responder: RTL and testbench
=====================================

Name: reg_file_responder

Overview:
Architectural integer register file (x0..x31) that serves the ID stage's register-access interface. It answers the ID stage's two read addresses combinationally and commits its write address/value pair on the clock edge. After reset it clears itself with an init sequencer. A req/ack debug port lets the bench preload and inspect registers without touching the pipeline.

Parameters:
NUM_REGS, 32, number of architectural registers; index width is log2(NUM_REGS)=5.
XLEN, 32, register data width.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_pc_reg_addr1  in  32  read address 1 from ID; low 5 bits index
load_pc_reg_addr2  in  32  read address 2 from ID
load_pc_reg_value1  out  32  read data 1, combinational
load_pc_reg_value2  out  32  read data 2, combinational
write_pc_reg_addr  in  32  write address from ID; 0 means no write
write_pc_reg_value  in  32  write data from ID
dbg_req  in  1  debug transaction request, held until dbg_ack
dbg_we  in  1  1 = debug write, 0 = debug read; sampled with dbg_req
dbg_addr  in  5  debug register index
dbg_wdata  in  32  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  32  debug read data, valid while dbg_ack=1
init_busy  out  1  1 while init clear sequence runs
addr_err  out  1  sticky flag: any ID address had bits [31:5] nonzero

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Reset values: dbg_ack=0, dbg_rdata=0, init_busy=1, addr_err=0, init counter=1, FSM=INIT. Register contents are not reset directly; the INIT state clears them.
- FSM has three states: INIT, IDLE, DACK.
- INIT:
  - Clears one register per cycle, index 1 up to 31 (31 cycles).
  - init_busy=1. Pipeline writes and debug requests are ignored; dbg_ack stays 0.
  - After index 31 is cleared, the FSM moves to IDLE and init_busy drops on the next cycle.
- IDLE:
  - If dbg_req=1 and the request does not conflict, the request is accepted and the FSM moves to DACK.
  - A conflict is dbg_we=1 with dbg_addr equal to a nonzero write_pc_reg_addr[4:0] in the same cycle. The request stays pending until the conflict clears.
- DACK:
  - dbg_ack=1 for exactly one cycle, then the FSM returns to IDLE.
  - Debug write: the write commits on the accepting edge.
  - Debug read: dbg_rdata holds the register value sampled at the accepting edge.
  - Maximum rate is one debug transaction per 2 cycles. A dbg_req still high in the IDLE cycle after DACK is a new request.
- Reads:
  - load_pc_reg_valueN = regs[addrN[4:0]]; index 0 always reads 0.
  - If addrN[31:5] is nonzero, the read returns 0 and addr_err sets on the next edge.
  - During INIT, reads return 0.
- Pipeline write:
  - At a rising edge outside INIT, the write commits when write_pc_reg_addr[4:0] is nonzero and write_pc_reg_addr[31:5] is 0.
  - Address 0 or an out-of-range address writes nothing; an out-of-range address sets addr_err.
- Simultaneous pipeline and debug writes to different registers: both commit on the same edge.
- x0 is never written, not even by the debug port; a debug read of x0 returns 0.
- addr_err clears only on reset.
- Reset asserted mid-operation (including in DACK) aborts any transaction with no ack and restarts INIT.

Optional Feature:
RF_BYPASS_EN
- Defined: when a read address (nonzero, in range, outside INIT) equals the committing pipeline write address in the same cycle, load_pc_reg_valueN returns write_pc_reg_value combinationally (write-first).
- Undefined: that read returns the old stored value; the new value is visible from the next cycle.
- Debug reads never bypass.

Test Plan:
- Reset for 1 cycle, release -> init_busy=1 for exactly 31 cycles then 0; all 32 reads return 0x00000000.
- Debug write x5=0xDEADBEEF, then set load_pc_reg_addr1=5 -> load_pc_reg_value1=0xDEADBEEF; debug read x5 -> dbg_ack pulses 1 cycle with dbg_rdata=0xDEADBEEF.
- write_pc_reg_addr=0 with value 0x1234, and a debug write x0=0xFFFFFFFF -> x0 still reads 0; no register changes.
- write_pc_reg_addr=7 with value 0xA5A5A5A5 and load_pc_reg_addr2=7 in the same cycle -> value2=0xA5A5A5A5 that cycle when RF_BYPASS_EN is defined, the old value 0 when undefined; 0xA5A5A5A5 next cycle in both builds.
- Pipeline write x9=0x11 while a debug write to x9 is pending -> dbg_ack is delayed until the pipeline write ends; final x9 holds the debug data.
- load_pc_reg_addr1=0x00000020 -> value1=0 and addr_err=1 from the next cycle onward, until reset; assert reset during DACK -> no dbg_ack and INIT restarts.

Source files
------------

// File: rtl/reg_file_responder_if.sv
// Register-access bundle between the ID stage / debug host and the register file.
// master drives addresses, write data and debug requests; slave answers them.
interface reg_file_responder_if #(
  parameter int XLEN = 32,
  parameter int IW   = 5
);
  logic [XLEN-1:0] load_pc_reg_addr1;
  logic [XLEN-1:0] load_pc_reg_addr2;
  logic [XLEN-1:0] load_pc_reg_value1;
  logic [XLEN-1:0] load_pc_reg_value2;
  logic [XLEN-1:0] write_pc_reg_addr;
  logic [XLEN-1:0] write_pc_reg_value;
  logic            dbg_req;
  logic            dbg_we;
  logic [IW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;
  logic            init_busy;
  logic            addr_err;

  modport master (
    output load_pc_reg_addr1, load_pc_reg_addr2, write_pc_reg_addr, write_pc_reg_value,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  load_pc_reg_value1, load_pc_reg_value2, dbg_ack, dbg_rdata, init_busy, addr_err
  );

  modport slave (
    input  load_pc_reg_addr1, load_pc_reg_addr2, write_pc_reg_addr, write_pc_reg_value,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output load_pc_reg_value1, load_pc_reg_value2, dbg_ack, dbg_rdata, init_busy, addr_err
  );
endinterface

// File: rtl/reg_file_responder.sv
// Architectural register file x0..x31 with post-reset clear sequencer and debug port.
// Optional macro RF_BYPASS_EN: write-first forwarding of the committing pipeline write to reads.
module reg_file_responder #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input logic                clk,
  input logic                reset,
  reg_file_responder_if.slave rf
);
  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DACK} state_e;

  state_e          state_q;
  logic [IW-1:0]   init_cnt_q;
  logic            init_busy_q;
  logic            dbg_ack_q;
  logic [XLEN-1:0] dbg_rdata_q;
  logic            addr_err_q;
  logic [XLEN-1:0] regs [NUM_REGS];

  logic          in_init;
  logic [IW-1:0] wr_idx;
  logic          wr_in_range;
  logic          pipe_we;
  logic          dbg_conflict;
  logic          dbg_accept;
  logic          dbg_wr_en;
  logic          addr_bad;

  assign in_init      = (state_q == ST_INIT);
  assign wr_idx       = rf.write_pc_reg_addr[IW-1:0];
  assign wr_in_range  = (rf.write_pc_reg_addr[XLEN-1:IW] == '0);
  assign pipe_we      = !in_init && (wr_idx != '0) && wr_in_range;
  // A debug write aimed at the register the pipeline is writing waits, so the pipeline never loses its data.
  assign dbg_conflict = rf.dbg_we && (wr_idx != '0) && (rf.dbg_addr == wr_idx);
  assign dbg_accept   = (state_q == ST_IDLE) && rf.dbg_req && !dbg_conflict;
  assign dbg_wr_en    = dbg_accept && rf.dbg_we && (rf.dbg_addr != '0);
  assign addr_bad     = (rf.load_pc_reg_addr1[XLEN-1:IW] != '0) ||
                        (rf.load_pc_reg_addr2[XLEN-1:IW] != '0) || !wr_in_range;

  function automatic logic [XLEN-1:0] read_port(input logic [XLEN-1:0] addr);
    logic [IW-1:0] idx;
    idx = addr[IW-1:0];
    if (in_init || (addr[XLEN-1:IW] != '0) || (idx == '0))
      return '0;
`ifdef RF_BYPASS_EN
    if (pipe_we && (idx == wr_idx))
      return rf.write_pc_reg_value;
`endif
    return regs[idx];
  endfunction

  always_comb begin
    rf.load_pc_reg_value1 = read_port(rf.load_pc_reg_addr1);
    rf.load_pc_reg_value2 = read_port(rf.load_pc_reg_addr2);
  end

  // NOTE: the storage array has no reset branch; the INIT sequence clears it, keeping it RAM-mappable.
  always_ff @(posedge clk) begin
    if (in_init)
      regs[init_cnt_q] <= '0;
    if (pipe_we)
      regs[wr_idx] <= rf.write_pc_reg_value;
    if (dbg_wr_en)
      regs[rf.dbg_addr] <= rf.dbg_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= IW'(1);
      init_busy_q <= 1'b1;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      dbg_ack_q  <= 1'b0;
      addr_err_q <= addr_err_q | addr_bad;
      unique case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + IW'(1);
          if (init_cnt_q == IW'(NUM_REGS - 1)) begin
            state_q     <= ST_IDLE;
            init_busy_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (dbg_accept) begin
            state_q   <= ST_DACK;
            dbg_ack_q <= 1'b1;
            if (!rf.dbg_we)
              dbg_rdata_q <= (rf.dbg_addr == '0) ? '0 : regs[rf.dbg_addr];
          end
        end
        ST_DACK: state_q <= ST_IDLE;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign rf.dbg_ack   = dbg_ack_q;
  assign rf.dbg_rdata = dbg_rdata_q;
  assign rf.init_busy = init_busy_q;
  assign rf.addr_err  = addr_err_q;
endmodule

// File: tb/tb_reg_file_responder.sv
// Directed self-checking bench for reg_file_responder (define RF_BYPASS_EN to check the bypass build).
module tb_reg_file_responder;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  reg_file_responder_if #(.XLEN(32), .IW(5)) rf ();

  reg_file_responder #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Count cycles from now until init_busy falls, bounded.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (rf.init_busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  // Hold a debug request until ack; report cycles to ack (0 = never acked within budget).
  task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
    rf.dbg_req   = 1'b1;
    rf.dbg_we    = we;
    rf.dbg_addr  = addr;
    rf.dbg_wdata = wdata;
    lat = 0;
    rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rf.dbg_ack === 1'b1) begin
        lat = i;
        rdata = rf.dbg_rdata;
        break;
      end
    end
    rf.dbg_req = 1'b0;
    rf.dbg_we  = 1'b0;
  endtask

  task automatic read1(input logic [31:0] addr, output logic [31:0] val);
    rf.load_pc_reg_addr1 = addr;
    #1;
    val = rf.load_pc_reg_value1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] v;
    logic [31:0] exp_byp;
    int          lat;
    int          busy;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    rf.load_pc_reg_addr1  = '0;
    rf.load_pc_reg_addr2  = '0;
    rf.write_pc_reg_addr  = '0;
    rf.write_pc_reg_value = '0;
    rf.dbg_req   = 1'b0;
    rf.dbg_we    = 1'b0;
    rf.dbg_addr  = '0;
    rf.dbg_wdata = '0;

    // Reset state
    tick();
    check("rst_busy", 32'(rf.init_busy), 32'd1);
    check("rst_ack", 32'(rf.dbg_ack), 32'd0);
    check("rst_rdata", rf.dbg_rdata, 32'd0);
    check("rst_err", 32'(rf.addr_err), 32'd0);
    reset = 1'b0;
    read1(32'd3, v);
    check("init_read", v, 32'd0);

    // Pending debug request during INIT is ignored; init lasts exactly 31 cycles
    rf.dbg_req = 1'b1;
    rf.dbg_we  = 1'b1;
    rf.dbg_addr = 5'd4;
    rf.dbg_wdata = 32'hBAD0BAD0;
    count_busy(busy);
    check("init_len", 32'(busy), 32'd31);
    check("init_no_ack", 32'(rf.dbg_ack), 32'd0);
    rf.dbg_req = 1'b0;
    rf.dbg_we  = 1'b0;
    tick();
    tick();
    check("init_req_ignored_ack", 32'(rf.dbg_ack), 32'd0);

    for (int i = 0; i < 32; i++) begin
      rf.load_pc_reg_addr1 = 32'(i);
      rf.load_pc_reg_addr2 = 32'(31 - i);
      #1;
      check($sformatf("clr_r1_x%0d", i), rf.load_pc_reg_value1, 32'd0);
      check($sformatf("clr_r2_x%0d", 31 - i), rf.load_pc_reg_value2, 32'd0);
    end

    // Debug write then read of x5
    dbg_txn(1'b1, 5'd5, 32'hDEADBEEF, rd, lat);
    check("dw5_lat", 32'(lat), 32'd1);
    tick();
    check("dw5_ack_drop", 32'(rf.dbg_ack), 32'd0);
    read1(32'd5, v);
    check("x5_pipe_read", v, 32'hDEADBEEF);
    dbg_txn(1'b0, 5'd5, 32'h0, rd, lat);
    check("dr5_lat", 32'(lat), 32'd1);
    check("dr5_data", rd, 32'hDEADBEEF);
    tick();
    check("dr5_ack_drop", 32'(rf.dbg_ack), 32'd0);

    // Writes to x0 from both sources do nothing
    rf.write_pc_reg_addr  = 32'd0;
    rf.write_pc_reg_value = 32'h1234;
    dbg_txn(1'b1, 5'd0, 32'hFFFFFFFF, rd, lat);
    check("dw0_lat", 32'(lat), 32'd1);
    tick();
    read1(32'd0, v);
    check("x0_read", v, 32'd0);
    read1(32'd1, v);
    check("x1_unchanged", v, 32'd0);
    read1(32'd5, v);
    check("x5_unchanged", v, 32'hDEADBEEF);
    dbg_txn(1'b0, 5'd0, 32'h0, rd, lat);
    check("dr0_data", rd, 32'd0);
    tick();

    // Same-cycle write/read of x7
`ifdef RF_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0;
`endif
    rf.load_pc_reg_addr2  = 32'd7;
    rf.write_pc_reg_addr  = 32'd7;
    rf.write_pc_reg_value = 32'hA5A5A5A5;
    #1;
    check("x7_same_cycle", rf.load_pc_reg_value2, exp_byp);
    tick();
    rf.write_pc_reg_addr = 32'd0;
    #1;
    check("x7_next_cycle", rf.load_pc_reg_value2, 32'hA5A5A5A5);

    // Debug write to x9 stalls while the pipeline writes x9
    rf.write_pc_reg_addr  = 32'd9;
    rf.write_pc_reg_value = 32'h11;
    rf.dbg_req   = 1'b1;
    rf.dbg_we    = 1'b1;
    rf.dbg_addr  = 5'd9;
    rf.dbg_wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("x9_stall_%0d", i), 32'(rf.dbg_ack), 32'd0);
    end
    rf.write_pc_reg_addr = 32'd0;
    tick();
    check("x9_ack_after_conflict", 32'(rf.dbg_ack), 32'd1);
    rf.dbg_req = 1'b0;
    rf.dbg_we  = 1'b0;
    tick();
    check("x9_ack_one_cycle", 32'(rf.dbg_ack), 32'd0);
    read1(32'd9, v);
    check("x9_final", v, 32'h77);

    // Pipeline x10 and debug x11 on the same edge
    rf.write_pc_reg_addr  = 32'd10;
    rf.write_pc_reg_value = 32'hAA;
    dbg_txn(1'b1, 5'd11, 32'hBB, rd, lat);
    check("dual_lat", 32'(lat), 32'd1);
    rf.write_pc_reg_addr = 32'd0;
    tick();
    read1(32'd10, v);
    check("dual_x10", v, 32'hAA);
    read1(32'd11, v);
    check("dual_x11", v, 32'hBB);

    // Out-of-range addresses
    read1(32'h20, v);
    check("oor_read", v, 32'd0);
    check("oor_err_before_edge", 32'(rf.addr_err), 32'd0);
    tick();
    check("oor_err_set", 32'(rf.addr_err), 32'd1);
    rf.load_pc_reg_addr1  = 32'd5;
    rf.write_pc_reg_addr  = 32'h25;
    rf.write_pc_reg_value = 32'h999;
    tick();
    rf.write_pc_reg_addr = 32'd0;
    tick();
    check("oor_err_sticky", 32'(rf.addr_err), 32'd1);
    read1(32'd5, v);
    check("oor_write_dropped", v, 32'hDEADBEEF);

    // Reset during DACK aborts the transaction and restarts INIT
    rf.dbg_req  = 1'b1;
    rf.dbg_we   = 1'b0;
    rf.dbg_addr = 5'd5;
    tick();
    check("pre_rst_dack", 32'(rf.dbg_ack), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_dack_ack", 32'(rf.dbg_ack), 32'd0);
    check("rst_dack_busy", 32'(rf.init_busy), 32'd1);
    check("rst_dack_err", 32'(rf.addr_err), 32'd0);
    reset = 1'b0;
    count_busy(busy);
    check("reinit_len", 32'(busy), 32'd31);
    check("reinit_no_ack", 32'(rf.dbg_ack), 32'd0);
    rf.dbg_req = 1'b0;
    tick();
    read1(32'd5, v);
    check("reinit_x5_cleared", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
